sdram_arb: RTL

SDRAM_ARB -- requirements
Module: sdram_arb

---
 rtl/sdram_arb.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sdram_arb.sv
// Two-client round-robin arbiter in front of a single-command SDRAM controller.
// One command in flight at a time; read data is routed back to the granted client.
module sdram_arb #(
    parameter int unsigned addrBits = 24,
    parameter int unsigned dataBits = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req0,
    input  logic                we0,
    input  logic [addrBits-1:0] addr0,
    input  logic [dataBits-1:0] wdata0,
    output logic                ack0,
    output logic                rvalid0,
    output logic [dataBits-1:0] rdata0,
    input  logic                req1,
    input  logic                we1,
    input  logic [addrBits-1:0] addr1,
    input  logic [dataBits-1:0] wdata1,
    output logic                ack1,
    output logic                rvalid1,
    output logic [dataBits-1:0] rdata1,
    output logic [addrBits-1:0] c_addr,
    output logic                c_r,
    output logic                c_w,
    output logic [dataBits-1:0] c_dw,
    input  logic [dataBits-1:0] c_dr,
    input  logic                c_busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;     // client owning the in-flight command
    logic   last_q, last_d;   // client granted most recently
    logic   rd_q, rd_d;       // in-flight command is a read

    logic                c_r_d, c_w_d, ack0_d, ack1_d, rvalid0_d, rvalid1_d;
    logic [addrBits-1:0] c_addr_d;
    logic [dataBits-1:0] c_dw_d, rdata0_d, rdata1_d;

    logic pick, pick_we;

    // Round-robin winner: on contention the client not granted last.
    assign pick    = (req0 && req1) ? ~last_q : req1;
    assign pick_we = pick ? we1 : we0;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        rd_d      = rd_q;
        c_r_d     = 1'b0;
        c_w_d     = 1'b0;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        c_addr_d  = c_addr;
        c_dw_d    = c_dw;
        rdata0_d  = rdata0;
        rdata1_d  = rdata1;

        case (state_q)
            IDLE: begin
                if (!c_busy && (req0 || req1)) begin
                    state_d  = WAIT_BUSY;
                    gnt_d    = pick;
                    last_d   = pick;
                    rd_d     = ~pick_we;
                    c_addr_d = pick ? addr1 : addr0;
                    c_dw_d   = pick ? wdata1 : wdata0;
                    c_r_d    = ~pick_we;
                    c_w_d    = pick_we;
                    ack0_d   = ~pick;
                    ack1_d   = pick;
                end
            end
            WAIT_BUSY: begin
                if (c_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // Controller finished: read data is valid on c_dr this cycle.
                if (!c_busy) begin
                    state_d = IDLE;
                    if (rd_q) begin
                        if (gnt_q) begin
                            rdata1_d  = c_dr;
                            rvalid1_d = 1'b1;
                        end else begin
                            rdata0_d  = c_dr;
                            rvalid0_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            rd_q    <= 1'b0;
            c_r     <= 1'b0;
            c_w     <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            c_addr  <= '0;
            c_dw    <= '0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            c_r     <= c_r_d;
            c_w     <= c_w_d;
            ack0    <= ack0_d;
            ack1    <= ack1_d;
            rvalid0 <= rvalid0_d;
            rvalid1 <= rvalid1_d;
            c_addr  <= c_addr_d;
            c_dw    <= c_dw_d;
            rdata0  <= rdata0_d;
            rdata1  <= rdata1_d;
        end
    end

endmodule
